// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the multi-port register file: default geometry,
// the hard-wired zero address and the write-to-read bypass priority (W1 over W0).
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;
    localparam int ZERO_ADDR  = 0;

    typedef enum logic [1:0] {
        BYP_NONE = 2'd0,
        BYP_W0   = 2'd1,
        BYP_W1   = 2'd2
    } bypSelT;

    // The load port is the later writer in the pipeline, so its data is the newest.
    function automatic bypSelT bypSelect(input logic hitW0, input logic hitW1);
        if (hitW1) return BYP_W1;
        if (hitW0) return BYP_W0;
        return BYP_NONE;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Port bundle between decode/writeback and the register file.
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    // No valid/ready handshake: RegWr, LdWr and Issue are single-cycle strobes
    // sampled on every rising clk edge; reads are purely combinational.
    logic                     RegWr;
    logic [ADDR_W-1:0]        Rw;
    logic [DATA_W-1:0]        busW;
    logic                     LdWr;
    logic [ADDR_W-1:0]        Lw;
    logic [DATA_W-1:0]        busL;
    logic                     Issue;
    logic [ADDR_W-1:0]        Rd_iss;
    logic [NUM_RD*ADDR_W-1:0] Ra;
    logic [NUM_RD*DATA_W-1:0] busA;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     iss_busy;
    logic                     wr_conflict;

    modport master (
        output RegWr, Rw, busW, LdWr, Lw, busL, Issue, Rd_iss, Ra,
        input  busA, rd_busy, iss_busy, wr_conflict
    );

    modport slave (
        input  RegWr, Rw, busW, LdWr, Lw, busL, Issue, Rd_iss, Ra,
        output busA, rd_busy, iss_busy, wr_conflict
    );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register load-pending bits with set-over-clear arbitration and read-port lookup.
// REG_FILE_BYPASS_EN: a same-cycle load writeback hides the busy bit it is about to clear.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue,
    input  logic [ADDR_W-1:0]        rdIss,
    input  logic                     ldWr,
    input  logic [ADDR_W-1:0]        lw,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD-1:0]        rdBusy,
    output logic                     issBusy
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busyQ;
    logic [DEPTH-1:0] busyD;
    logic             setEn;

    assign setEn = issue && !((ZERO_REG != 0) && (rdIss == ADDR_W'(ZERO_ADDR)));

    // Set is applied last so a new issue outranks a completing load on the same register.
    always_comb begin
        busyD = busyQ;
        if (ldWr)  busyD[lw]    = 1'b0;
        if (setEn) busyD[rdIss] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busyQ <= '0;
        else      busyQ <= busyD;
    end

    assign issBusy = rst && issue && busyQ[rdIss];

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit;
        assign addr = ra[k*ADDR_W +: ADDR_W];
`ifdef REG_FILE_BYPASS_EN
        assign hit = busyQ[addr] && !(ldWr && (lw == addr) && !(setEn && (rdIss == addr)));
`else
        assign hit = busyQ[addr];
`endif
        assign rdBusy[k] = rst && hit;
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational reads, ALU (W0) and load (W1) writes,
// load scoreboard. Define REG_FILE_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst,
    reg_file_mp_if.slave rf
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              sameAddr;
    logic              w0En;
    logic              w1En;
    logic              wrConflictQ;

    assign sameAddr = (rf.Rw == rf.Lw);
    assign w1En = rf.LdWr && !((ZERO_REG != 0) && (rf.Lw == ADDR_W'(ZERO_ADDR)));
    // W0 backs off entirely when the load port hits the same register.
    assign w0En = rf.RegWr && !((ZERO_REG != 0) && (rf.Rw == ADDR_W'(ZERO_ADDR)))
                  && !(rf.LdWr && sameAddr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (w0En) regs[rf.Rw] <= rf.busW;
            if (w1En) regs[rf.Lw] <= rf.busL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wrConflictQ <= 1'b0;
        else      wrConflictQ <= rf.RegWr && rf.LdWr && sameAddr;
    end

    assign rf.wr_conflict = wrConflictQ;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        assign addr = rf.Ra[k*ADDR_W +: ADDR_W];
`ifdef REG_FILE_BYPASS_EN
        always_comb begin
            data = regs[addr];
            case (bypSelect(w0En && (rf.Rw == addr), w1En && (rf.Lw == addr)))
                BYP_W1:  data = rf.busL;
                BYP_W0:  data = rf.busW;
                default: data = regs[addr];
            endcase
        end
`else
        assign data = regs[addr];
`endif
        assign rf.busA[k*DATA_W +: DATA_W] = rst ? data : '0;
    end

    reg_scoreboard #(
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .ZERO_REG(ZERO_REG)
    ) u_scoreboard (
        .clk    (clk),
        .rst    (rst),
        .issue  (rf.Issue),
        .rdIss  (rf.Rd_iss),
        .ldWr   (rf.LdWr),
        .lw     (rf.Lw),
        .ra     (rf.Ra),
        .rdBusy (rf.rd_busy),
        .issBusy(rf.iss_busy)
    );

endmodule
